// File: rtl/mod_split_nested_decoder.sv
// mod_split_nested_decoder
// Passive observer beside the split-nested register block. It rebuilds the
// cond1/cond2 branch that produced each (out_nested_a, out_nested_b) pair,
// classifies the pair, keeps saturating per-class counts, and raises a
// sticky error on pairs the nested-assignment register can never produce.
module mod_split_nested_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic [7:0]       obs_a,
    input  logic [7:0]       obs_b,
    input  logic             clr_cnt,
    output logic             dec_valid,
    output logic [2:0]       dec_class,
    output logic             dec_cond1,
    output logic             dec_cond2,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cnt_c1,
    output logic [CNT_W-1:0] cnt_c12,
    output logic [CNT_W-1:0] cnt_else,
    output logic [CNT_W-1:0] cnt_err
);

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam logic [2:0] CL_C1      = 3'd1;
    localparam logic [2:0] CL_C12     = 3'd2;
    localparam logic [2:0] CL_ELSE    = 3'd3;
    localparam logic [2:0] CL_DEF     = 3'd4;
    localparam logic [2:0] CL_ZERO    = 3'd5;
    localparam logic [2:0] CL_SPLIT   = 3'd6;
    localparam logic [2:0] CL_INVALID = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0] state;
    logic [7:0] data_q;

    logic [7:0] c1_a, c1_b, c12_a, c12_b, ce_a, ce_b;
    logic       m_c1, m_c12, m_else, m_def, m_zero;
    logic       a_any, b_any;
    logic [2:0] cls;
    logic       cond1_n, cond2_n;
    logic       track;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == '1) ? v : v + CNT_ONE;
    endfunction

    assign track = (state == ST_TRACK);

    // Candidate pairs for the byte the observed block consumed, and the classification.
    always_comb begin
        c1_a  = data_q + 8'd10;
        c1_b  = data_q + 8'd20;
        c12_a = data_q + 8'd100;
        c12_b = data_q + 8'd200;
        ce_a  = data_q - 8'd10;
        ce_b  = data_q - 8'd20;

        m_c12  = (obs_a == c12_a) && (obs_b == c12_b);
        m_c1   = (obs_a == c1_a)  && (obs_b == c1_b);
        m_else = (obs_a == ce_a)  && (obs_b == ce_b);
        m_def  = (obs_a == 8'h11) && (obs_b == 8'h22);
        m_zero = (obs_a == 8'h00) && (obs_b == 8'h00);

        a_any = (obs_a == c1_a) || (obs_a == c12_a) || (obs_a == ce_a) ||
                (obs_a == 8'h11) || (obs_a == 8'h00);
        b_any = (obs_b == c1_b) || (obs_b == c12_b) || (obs_b == ce_b) ||
                (obs_b == 8'h22) || (obs_b == 8'h00);

        cls     = CL_INVALID;
        cond1_n = 1'b0;
        cond2_n = 1'b0;
        if (m_c12) begin
            cls     = CL_C12;
            cond1_n = 1'b1;
            cond2_n = 1'b1;
        end else if (m_c1) begin
            cls     = CL_C1;
            cond1_n = 1'b1;
        end else if (m_else) begin
            cls = CL_ELSE;
        end else if (m_def) begin
            cls = CL_DEF;
        end else if (m_zero) begin
            cls = CL_ZERO;
        end else if (a_any || b_any) begin
            // Components drawn from mismatched candidates: the split lost a pairing.
            cls = CL_SPLIT;
        end
    end

    // Stimulus alignment register and PRIME/TRACK sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_PRIME;
            data_q <= '0;
        end else begin
            data_q <= data_in;
            state  <= ST_TRACK;
        end
    end

    // Registered decode outputs; the PRIME edge leaves them at their reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_valid <= 1'b0;
            dec_class <= '0;
            dec_cond1 <= 1'b0;
            dec_cond2 <= 1'b0;
        end else if (track) begin
            dec_valid <= 1'b1;
            dec_class <= cls;
            dec_cond1 <= cond1_n;
            dec_cond2 <= cond2_n;
        end
    end

    // Saturating class counters and sticky error; clr_cnt wins over any increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_c1     <= '0;
            cnt_c12    <= '0;
            cnt_else   <= '0;
            cnt_err    <= '0;
            err_sticky <= 1'b0;
        end else if (clr_cnt) begin
            cnt_c1     <= '0;
            cnt_c12    <= '0;
            cnt_else   <= '0;
            cnt_err    <= '0;
            err_sticky <= 1'b0;
        end else if (track) begin
            if (cls == CL_C1)   cnt_c1   <= sat_inc(cnt_c1);
            if (cls == CL_C12)  cnt_c12  <= sat_inc(cnt_c12);
            if (cls == CL_ELSE) cnt_else <= sat_inc(cnt_else);
            if (cls >= CL_DEF) begin
                cnt_err    <= sat_inc(cnt_err);
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_split_nested_decoder.sv
// Directed and random bench for mod_split_nested_decoder. The observed
// register block is modelled here so random cycles feed the decoder the
// same pairs the real block would produce.
module tb_mod_split_nested_decoder;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       data_in;
    logic [7:0]       obs_a, obs_b;
    logic             clr_cnt;
    logic             dec_valid;
    logic [2:0]       dec_class;
    logic             dec_cond1, dec_cond2;
    logic             err_sticky;
    logic [CNT_W-1:0] cnt_c1, cnt_c12, cnt_else, cnt_err;

    logic       use_model;
    logic [7:0] drv_a, drv_b;
    logic       cond1, cond2;
    logic [7:0] blk_a, blk_b;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    mod_split_nested_decoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .obs_a      (obs_a),
        .obs_b      (obs_b),
        .clr_cnt    (clr_cnt),
        .dec_valid  (dec_valid),
        .dec_class  (dec_class),
        .dec_cond1  (dec_cond1),
        .dec_cond2  (dec_cond2),
        .err_sticky (err_sticky),
        .cnt_c1     (cnt_c1),
        .cnt_c12    (cnt_c12),
        .cnt_else   (cnt_else),
        .cnt_err    (cnt_err)
    );

    always #5 clk = ~clk;

    // Reference model of the nested-assignment register block.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_a <= 8'h00;
            blk_b <= 8'h00;
        end else if (cond1) begin
            if (cond2) begin
                blk_a <= data_in + 8'd100;
                blk_b <= data_in + 8'd200;
            end else begin
                blk_a <= data_in + 8'd10;
                blk_b <= data_in + 8'd20;
            end
        end else begin
            blk_a <= data_in - 8'd10;
            blk_b <= data_in - 8'd20;
        end
    end

    assign obs_a = use_model ? blk_a : drv_a;
    assign obs_b = use_model ? blk_b : drv_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one stimulus byte and one observed pair, then move to the next falling edge.
    task automatic step(input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
        data_in = d;
        drv_a   = a;
        drv_b   = b;
        @(negedge clk);
    endtask

    task automatic check_decode(input string tag, input logic [2:0] cls,
                                input logic c1, input logic c2);
        check({tag, "_valid"}, 32'(dec_valid), 32'd1);
        check({tag, "_class"}, 32'(dec_class), 32'(cls));
        check({tag, "_cond1"}, 32'(dec_cond1), 32'(c1));
        check({tag, "_cond2"}, 32'(dec_cond2), 32'(c2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] c_now, c_d1, c_d2;

        reset     = 1'b1;
        data_in   = 8'h05;
        drv_a     = 8'h00;
        drv_b     = 8'h00;
        clr_cnt   = 1'b0;
        use_model = 1'b0;
        cond1     = 1'b0;
        cond2     = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_class", 32'(dec_class), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_cnt_c1", 32'(cnt_c1), 32'd0);
        check("rst_cnt_err", 32'(cnt_err), 32'd0);

        reset = 1'b0;
        @(negedge clk);
        check("prime_valid", 32'(dec_valid), 32'd0);
        check("prime_err", 32'(err_sticky), 32'd0);

        // d = 0x05 throughout these three
        step(8'h05, 8'h0F, 8'h19);
        check_decode("c1", 3'd1, 1'b1, 1'b0);
        check("c1_cnt", 32'(cnt_c1), 32'd1);
        step(8'h05, 8'h69, 8'hCD);
        check_decode("c12", 3'd2, 1'b1, 1'b1);
        check("c12_cnt", 32'(cnt_c12), 32'd1);
        step(8'hF0, 8'hFB, 8'hF1);
        check_decode("else", 3'd3, 1'b0, 1'b0);
        check("else_cnt", 32'(cnt_else), 32'd1);

        // Wrap-around: 0xF0 + 100/200, then 0x03 - 10/20
        step(8'h03, 8'h54, 8'hB8);
        check_decode("wrap_c12", 3'd2, 1'b1, 1'b1);
        check("wrap_c12_err", 32'(err_sticky), 32'd0);
        step(8'h05, 8'hF9, 8'hEF);
        check_decode("wrap_else", 3'd3, 1'b0, 1'b0);
        check("wrap_else_cnt", 32'(cnt_else), 32'd2);

        // Fault pairs, d = 0x05
        step(8'h05, 8'h0F, 8'h00);
        check_decode("split", 3'd6, 1'b0, 1'b0);
        check("split_err", 32'(err_sticky), 32'd1);
        check("split_cnt_err", 32'(cnt_err), 32'd1);
        step(8'h05, 8'h11, 8'h22);
        check_decode("def", 3'd4, 1'b0, 1'b0);
        check("def_cnt_err", 32'(cnt_err), 32'd2);
        step(8'h05, 8'h33, 8'h44);
        check_decode("invalid", 3'd7, 1'b0, 1'b0);
        step(8'h05, 8'h00, 8'h00);
        check_decode("zero", 3'd5, 1'b0, 1'b0);
        check("zero_cnt_err", 32'(cnt_err), 32'd4);
        check("c1_cnt_kept", 32'(cnt_c1), 32'd1);

        // Mid-stream reset clears asynchronously
        reset = 1'b1;
        #1;
        check("mrst_valid", 32'(dec_valid), 32'd0);
        check("mrst_class", 32'(dec_class), 32'd0);
        check("mrst_err", 32'(err_sticky), 32'd0);
        check("mrst_cnt_err", 32'(cnt_err), 32'd0);
        check("mrst_cnt_c1", 32'(cnt_c1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_prime_valid", 32'(dec_valid), 32'd0);
        check("mrst_prime_err", 32'(err_sticky), 32'd0);
        step(8'h05, 8'h0F, 8'h19);
        check_decode("mrst_resume", 3'd1, 1'b1, 1'b0);
        check("mrst_resume_err", 32'(err_sticky), 32'd0);
        check("mrst_resume_cnt_err", 32'(cnt_err), 32'd0);

        // Saturation then clear
        step(8'h05, 8'h33, 8'h44);
        check("sat_pre_err", 32'(cnt_err), 32'd1);
        for (int i = 0; i < 20; i++) step(8'h05, 8'h0F, 8'h19);
        check("sat_cnt_c1", 32'(cnt_c1), 32'd15);
        check("sat_err", 32'(err_sticky), 32'd1);
        clr_cnt = 1'b1;
        step(8'h05, 8'h0F, 8'h19);
        clr_cnt = 1'b0;
        check("clr_cnt_c1", 32'(cnt_c1), 32'd0);
        check("clr_cnt_err", 32'(cnt_err), 32'd0);
        check("clr_err", 32'(err_sticky), 32'd0);
        check_decode("clr_decode", 3'd1, 1'b1, 1'b0);

        // Random cycles through the block model
        use_model = 1'b1;
        c_d1 = '0;
        c_d2 = '0;
        for (int i = 0; i < 10000; i++) begin
            if (i >= 2) begin
                check("rnd_cond1", 32'(dec_cond1), 32'(c_d2[1]));
                check("rnd_cond2", 32'(dec_cond2), 32'(c_d2[1] & c_d2[0]));
            end
            c_now   = 2'($urandom_range(0, 3));
            cond1   = c_now[1];
            cond2   = c_now[0];
            data_in = 8'($urandom_range(0, 255));
            clr_cnt = (i == 2);
            c_d2 = c_d1;
            c_d1 = c_now;
            @(negedge clk);
        end
        clr_cnt = 1'b0;
        check("rnd_cnt_err", 32'(cnt_err), 32'd0);
        check("rnd_err", 32'(err_sticky), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
